// File: rtl/hbmc_bus_sequencer_if.sv
// Host-side command/write/read handshakes plus the per-pin HyperBus drive signals.
// Pure wiring bundle; no latency of its own.
// Backpressure is carried by cmd_ready and wr_ready; the sequencer side uses the slave modport.
interface hbmc_bus_sequencer_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic        cmd_reg;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  // write data from a show-ahead FIFO
  logic        wr_valid;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic        wr_ready;
  // read capture path and RWDS level
  logic        rd_word_valid;
  logic        rwds_in;
  // HyperBus pin control
  logic        hb_cs_n;
  logic        hb_ck_en;
  logic        dq_t;
  logic [15:0] dq_sdr;
  logic        rwds_t;
  logic [1:0]  rwds_sdr;
  // status
  logic        busy;
  logic        rd_timeout;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_reg, cmd_addr, cmd_len,
    input  wr_valid, wr_data, wr_mask,
    input  rd_word_valid, rwds_in,
    output cmd_ready, wr_ready,
    output hb_cs_n, hb_ck_en, dq_t, dq_sdr, rwds_t, rwds_sdr,
    output busy, rd_timeout
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_reg, cmd_addr, cmd_len,
    output wr_valid, wr_data, wr_mask,
    output rd_word_valid, rwds_in,
    input  cmd_ready, wr_ready,
    input  hb_cs_n, hb_ck_en, dq_t, dq_sdr, rwds_t, rwds_sdr,
    input  busy, rd_timeout
  );
endinterface

// File: rtl/hbmc_bus_sequencer.sv
// HyperBus transaction sequencer: CA phase, initial latency, write/read data phase, CS recovery.
// Latency: CA0 one clock after command handshake; data at +4+N (register write +4); idle TRWR+1 after last data.
// Backpressure: cmd_ready only in IDLE; write data popped as offered (dummy word or CK stall when empty).
module hbmc_bus_sequencer #(
  parameter int LATENCY    = 6,
  parameter int TRWR       = 2,
  parameter int RD_TIMEOUT = 32
) (
  input logic             clk,
  input logic             arstn,
  hbmc_bus_sequencer_if.slave bus
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CA0, CA1, CA2, LAT, WRITE, READ, RECOV} state_t;

  state_t        state;
  logic          wr_q;
  logic          reg_q;
  logic          dbl;
  logic [31:0]   ca_q;
  logic [8:0]    cnt;
  logic [7:0]    wait_cnt;
  logic [TW-1:0] tmr;
  logic          ready_q;
  logic          busy_q;
  logic          cs_n_q;
  logic          ck_en_q;
  logic          dq_t_q;
  logic          rwds_t_q;
  logic          tmo_q;
  logic [15:0]   dq_q;

  logic [47:0]   ca_new;
  logic          in_write;
  logic          wr_last;
  logic          rd_last;
  logic          rd_abort;
  logic          to_recov;

  // Command/address word built straight from the command inputs so CA0 can leave on the handshake edge.
  assign ca_new = {~bus.cmd_wr, bus.cmd_reg, 1'b1, bus.cmd_addr[31:3], 13'd0, bus.cmd_addr[2:0]};

  assign in_write = (state == WRITE);
  assign wr_last  = in_write && bus.wr_valid && (cnt == 9'd1);
  assign rd_last  = (state == READ) && bus.rd_word_valid && (cnt == 9'd1);
  assign rd_abort = (state == READ) && !bus.rd_word_valid && (tmr == TW'(RD_TIMEOUT - 2));
  assign to_recov = wr_last || rd_last || rd_abort;

  // Sequencer FSM; every pin-control output is registered alongside the state.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      reg_q    <= 1'b0;
      dbl      <= 1'b0;
      ca_q     <= 32'd0;
      cnt      <= 9'd0;
      wait_cnt <= 8'd0;
      tmr      <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ck_en_q  <= 1'b0;
      dq_t_q   <= 1'b1;
      rwds_t_q <= 1'b1;
      tmo_q    <= 1'b0;
      dq_q     <= 16'd0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            state   <= CA0;
            wr_q    <= bus.cmd_wr;
            reg_q   <= bus.cmd_reg;
            ca_q    <= ca_new[31:0];
            cnt     <= {bus.cmd_len == 8'd0, bus.cmd_len};
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            ck_en_q <= 1'b1;
            dq_t_q  <= 1'b0;
            dq_q    <= ca_new[47:32];
          end else begin
            ready_q <= 1'b1;
          end
        end
        CA0: begin
          state <= CA1;
          dq_q  <= ca_q[31:16];
        end
        CA1: begin
          state <= CA2;
          dq_q  <= ca_q[15:0];
          dbl   <= bus.rwds_in;
        end
        CA2: begin
          dq_q <= 16'd0;
          if (wr_q && reg_q) begin
            // register writes carry no latency and exactly one word
            state <= WRITE;
            cnt   <= 9'd1;
          end else begin
            state    <= LAT;
            dq_t_q   <= 1'b1;
            wait_cnt <= dbl ? 8'(2 * LATENCY - 1) : 8'(LATENCY - 1);
          end
        end
        LAT: begin
          if (wait_cnt == 8'd0) begin
            tmr <= '0;
            if (wr_q) begin
              state    <= WRITE;
              dq_t_q   <= 1'b0;
              rwds_t_q <= 1'b0;
            end else begin
              state <= READ;
            end
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        WRITE: begin
          if (bus.wr_valid) cnt <= cnt - 9'd1;
        end
        READ: begin
          if (bus.rd_word_valid) begin
            cnt <= cnt - 9'd1;
            tmr <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RECOV: begin
          if (wait_cnt == 8'd0) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (to_recov) begin
        state    <= RECOV;
        wait_cnt <= 8'(TRWR - 1);
        cs_n_q   <= 1'b1;
        ck_en_q  <= 1'b0;
        dq_t_q   <= 1'b1;
        rwds_t_q <= 1'b1;
        dq_q     <= 16'd0;
        tmo_q    <= rd_abort;
      end
    end
  end

  // In WRITE the FIFO head passes straight through so the pop strobe and its word share a cycle;
  // an empty FIFO sends a fully masked dummy word (memory) or stops CK (register).
  assign bus.wr_ready   = in_write & bus.wr_valid;
  assign bus.dq_sdr     = !in_write ? dq_q : (bus.wr_valid ? bus.wr_data : 16'h0000);
  assign bus.rwds_sdr   = !in_write ? 2'b00 : (bus.wr_valid ? bus.wr_mask : 2'b11);
  assign bus.hb_ck_en   = ck_en_q & ~(in_write & reg_q & ~bus.wr_valid);
  assign bus.cmd_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.hb_cs_n    = cs_n_q;
  assign bus.dq_t       = dq_t_q;
  assign bus.rwds_t     = rwds_t_q;
  assign bus.rd_timeout = tmo_q;

endmodule

// File: tb/tb_hbmc_bus_sequencer.sv
// Bench for hbmc_bus_sequencer: directed transactions plus random ones against a timeline model.
// The model derives each cycle's expected pin state from latency, burst length and data availability.
module tb_hbmc_bus_sequencer;
  localparam int LATENCY    = 6;
  localparam int TRWR       = 2;
  localparam int RD_TIMEOUT = 32;
  localparam int MAXC       = 1024;

  logic clk = 1'b0;
  logic arstn = 1'b0;

  hbmc_bus_sequencer_if bus();

  hbmc_bus_sequencer #(
    .LATENCY(LATENCY), .TRWR(TRWR), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .arstn(arstn), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit avail[MAXC];
  bit rv[MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command from handshake to the first IDLE cycle, every cycle checked against the timeline.
  task automatic run_txn(input string name, input bit wr, input bit rg, input logic [31:0] addr,
                         input logic [7:0] len, input bit dbl, input int amode, input int ret,
                         input int w0, input int rst_at);
    int n, lat, d0, end_c, e, k, prev, got, ti, r;
    bit abort, pop, in_ca, in_lat, in_dat;
    logic [47:0] ca;
    logic [17:0] w;
    logic [17:0] wq[$];
    logic [17:0] eq[$];
    lat = (wr && rg) ? 0 : (dbl ? 2 * LATENCY : LATENCY);
    d0  = 4 + lat;
    n   = (wr && rg) ? 1 : ((len == 8'd0) ? 256 : int'(len));
    r   = (ret < 0) ? n : ret;
    ca  = {~wr, rg, 1'b1, addr[31:3], 13'd0, addr[2:0]};
    for (int i = 0; i < MAXC; i++) begin avail[i] = 1'b1; rv[i] = 1'b0; end
    if (amode == 1) for (int i = 0; i < 600; i++) avail[i] = ($urandom_range(0, 3) != 0);
    if (amode == 2) for (int i = d0 + 1; i < d0 + 4; i++) avail[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = {2'($urandom), 16'($urandom)};
      if (i == 0 && w0 >= 0) w = 18'(w0);
      wq.push_back(w);
      eq.push_back(w);
    end
    abort = 1'b0;
    end_c = d0;
    if (wr) begin
      k = 0;
      for (int c = d0; c < MAXC; c++) if (avail[c]) begin
        k++;
        if (k == n) begin end_c = c; break; end
      end
    end else begin
      for (int c = 1; c < d0; c++) rv[c] = ($urandom_range(0, 3) == 0);
      ti = d0 + $urandom_range(0, 4);
      for (int i = 0; i < r; i++) begin rv[ti] = 1'b1; ti += 1 + $urandom_range(0, 4); end
      prev = d0 - 1;
      got  = 0;
      for (int c = d0; c < MAXC; c++) begin
        if (rv[c]) begin
          prev = c;
          got++;
          if (got == n) begin end_c = c; break; end
        end else if (c - prev == RD_TIMEOUT - 1) begin
          abort = 1'b1;
          end_c = c;
          break;
        end
      end
      for (int c = end_c + 1; c <= end_c + TRWR; c++) rv[c] = ($urandom_range(0, 1) == 1);
    end
    e = end_c + TRWR + 1;

    ti = 0;
    @(negedge clk);
    while (!bus.cmd_ready && ti < 50) begin @(negedge clk); ti++; end
    chk({name, " ready_before_cmd"}, 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_reg   = rg;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = ~wr;
    bus.cmd_reg   = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_len   = 8'($urandom);
    k = 0;
    for (int c = 1; c <= e; c++) begin
      bus.rwds_in       = (c == 2) ? dbl : ~dbl;
      bus.rd_word_valid = rv[c];
      bus.wr_valid      = avail[c] && (wq.size() > 0);
      w                 = (wq.size() > 0) ? wq[0] : 18'd0;
      bus.wr_data       = w[15:0];
      bus.wr_mask       = w[17:16];
      @(negedge clk);
      in_ca  = (c <= 3);
      in_lat = (c > 3) && (c < d0);
      in_dat = (c >= d0) && (c <= end_c);
      chk($sformatf("%s c%0d cs_n", name, c), 32'(bus.hb_cs_n), (c <= end_c) ? 0 : 1);
      chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), (c < e) ? 1 : 0);
      chk($sformatf("%s c%0d cmd_ready", name, c), 32'(bus.cmd_ready), (c == e) ? 1 : 0);
      chk($sformatf("%s c%0d ck_en", name, c), 32'(bus.hb_ck_en),
          (in_ca || in_lat) ? 1 : (in_dat ? ((wr && rg && !avail[c]) ? 0 : 1) : 0));
      chk($sformatf("%s c%0d dq_t", name, c), 32'(bus.dq_t),
          in_ca ? 0 : (in_lat ? 1 : (in_dat ? (wr ? 0 : 1) : 1)));
      chk($sformatf("%s c%0d rwds_t", name, c), 32'(bus.rwds_t), (in_dat && wr && !rg) ? 0 : 1);
      chk($sformatf("%s c%0d wr_ready", name, c), 32'(bus.wr_ready), (in_dat && wr && avail[c]) ? 1 : 0);
      chk($sformatf("%s c%0d rd_timeout", name, c), 32'(bus.rd_timeout), (abort && c == end_c + 1) ? 1 : 0);
      if (in_ca)
        chk($sformatf("%s c%0d ca_slice", name, c), 32'(bus.dq_sdr),
            32'((c == 1) ? ca[47:32] : ((c == 2) ? ca[31:16] : ca[15:0])));
      if (in_lat) chk($sformatf("%s c%0d lat_dq", name, c), 32'(bus.dq_sdr), 0);
      if (in_dat && wr && avail[c] && k < eq.size()) begin
        w = eq[k];
        chk($sformatf("%s c%0d wdata", name, c), 32'(bus.dq_sdr), 32'(w[15:0]));
        chk($sformatf("%s c%0d wmask", name, c), 32'(bus.rwds_sdr), 32'(w[17:16]));
        k++;
      end else if (in_dat && wr && !rg) begin
        chk($sformatf("%s c%0d dummy_mask", name, c), 32'(bus.rwds_sdr), 3);
      end
      pop = bus.wr_ready && bus.wr_valid;
      if (rst_at == c) begin
        #2 arstn = 1'b0;
        #1;
        chk({name, " async_cs_n"}, 32'(bus.hb_cs_n), 1);
        chk({name, " async_dq_t"}, 32'(bus.dq_t), 1);
        chk({name, " async_rwds_t"}, 32'(bus.rwds_t), 1);
        chk({name, " async_busy"}, 32'(bus.busy), 0);
        chk({name, " async_ready"}, 32'(bus.cmd_ready), 0);
        bus.wr_valid      = 1'b0;
        bus.rd_word_valid = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk({name, " ready_after_release"}, 32'(bus.cmd_ready), 1);
        return;
      end
      @(posedge clk);
      #1;
      if (pop) void'(wq.pop_front());
    end
    bus.rd_word_valid = 1'b0;
    bus.wr_valid      = 1'b0;
    if (wr) chk({name, " words_left"}, 32'(wq.size()), 0);
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_wr        = 1'b0;
    bus.cmd_reg       = 1'b0;
    bus.cmd_addr      = 32'd0;
    bus.cmd_len       = 8'd0;
    bus.wr_valid      = 1'b0;
    bus.wr_data       = 16'd0;
    bus.wr_mask       = 2'd0;
    bus.rd_word_valid = 1'b0;
    bus.rwds_in       = 1'b0;

    // Reset values while arstn is held low across a clock edge.
    #12;
    chk("rst cs_n", 32'(bus.hb_cs_n), 1);
    chk("rst dq_t", 32'(bus.dq_t), 1);
    chk("rst rwds_t", 32'(bus.rwds_t), 1);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst ck_en", 32'(bus.hb_ck_en), 0);
    chk("rst wr_ready", 32'(bus.wr_ready), 0);
    chk("rst rd_timeout", 32'(bus.rd_timeout), 0);
    chk("rst dq_sdr", 32'(bus.dq_sdr), 0);
    chk("rst rwds_sdr", 32'(bus.rwds_sdr), 0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("first_clock_ready", 32'(bus.cmd_ready), 1);

    // Memory write, CA slices 0x2000/0x0002/0x0003, single latency, two words.
    run_txn("mem_wr_13", 1'b1, 1'b0, 32'h0000_0013, 8'd2, 1'b0, 0, -1, -1, 0);
    // Memory read with double latency requested in CA1.
    run_txn("mem_rd_dbl", 1'b0, 1'b0, $urandom, 8'd4, 1'b1, 0, -1, -1, 0);
    // Register write, no latency, one word.
    run_txn("reg_wr", 1'b1, 1'b1, $urandom, 8'd1, 1'b0, 0, -1, 32'h0_8F1F, 0);
    // Memory write with three empty-FIFO cycles after the first word.
    run_txn("mem_wr_gap", 1'b1, 1'b0, $urandom, 8'd4, 1'b0, 2, -1, -1, 0);
    // Read of 8 words where only 3 come back.
    run_txn("rd_timeout", 1'b0, 1'b0, $urandom, 8'd8, 1'b0, 0, 3, -1, 0);
    // Register write with a stalling FIFO.
    run_txn("reg_wr_stall", 1'b1, 1'b1, $urandom, 8'd7, 1'b1, 1, -1, -1, 0);
    // Random mix of commands and data availability.
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              8'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 1, -1, -1, 0);
    // Length 0 means a 256-word burst.
    run_txn("mem_wr_256", 1'b1, 1'b0, $urandom, 8'd0, 1'b0, 1, -1, -1, 0);
    // Reset mid-WRITE, then a normal command.
    run_txn("rst_mid_wr", 1'b1, 1'b0, $urandom, 8'd8, 1'b0, 0, -1, -1, 4 + LATENCY + 1);
    run_txn("post_rst_rd", 1'b0, 1'b1, $urandom, 8'd3, 1'b0, 0, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
